// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: SPI scan controller for ADC088S102/108S102/128S102.
// Round-robins NUM_CH inputs, one CS frame per conversion, and keeps a
// per-channel result (raw or IIR-smoothed) for combinational readback.
`timescale 1ns/1ps
module adc_scan_ctrl #(
  parameter int ADC_BITS     = 8,
  parameter int NUM_CH       = 8,
  parameter int SCK_DIV      = 1,
  parameter int SMOOTH_SHIFT = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  output logic                sck,
  output logic                cs_n,
  input  logic                din,
  output logic                dout,
  input  logic [2:0]          addr,
  output logic [ADC_BITS-1:0] q,
  output logic [NUM_CH-1:0]   ch_valid,
  output logic                smp_stb,
  output logic [2:0]          smp_ch,
  output logic [ADC_BITS-1:0] smp_data
);

  localparam int            CW       = $clog2(2 * SCK_DIV) + 1;
  localparam logic [CW-1:0] D_LAST   = CW'(SCK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(2 * SCK_DIV - 1);
  localparam logic [2:0]    CH_LAST  = 3'(NUM_CH - 1);
  localparam logic [4:0]    WIN_LO   = 5'd4;
  localparam logic [4:0]    WIN_HI   = 5'(4 + ADC_BITS);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, STORE, GAP} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic                phase, phase_n;   // 0 = SCK low half, 1 = SCK high half
  logic [3:0]          bitcnt, bitcnt_n;
  logic                sample, store;

  logic [ADC_BITS-1:0] rx;
  logic [2:0]          cur_ch, nxt_ch;
  logic [15:0]         tx;
  logic [ADC_BITS-1:0] mem [NUM_CH];
  logic [NUM_CH-1:0]   valid;
  logic [ADC_BITS-1:0] y_cur, y_new;
  logic                vld_cur;
  logic                in_window;

  logic signed [ADC_BITS:0] diff, step, sum;

  assign nxt_ch    = (cur_ch >= CH_LAST) ? 3'd0 : cur_ch + 3'd1;
  assign tx        = {2'b00, nxt_ch, 11'd0};
  assign in_window = ({1'b0, bitcnt} >= WIN_LO) && ({1'b0, bitcnt} < WIN_HI);

  assign sck      = !((state == SHIFT) && !phase);
  assign cs_n     = !((state == SETUP) || (state == SHIFT));
  assign dout     = (state == SHIFT) ? tx[4'd15 - bitcnt] : 1'b0;
  assign ch_valid = valid;

  // FSM state and frame timing counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      phase  <= 1'b0;
      bitcnt <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      phase  <= phase_n;
      bitcnt <= bitcnt_n;
    end
  end

  // Next-state logic; sample marks the clk where SCK rises, store the STORE cycle
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    phase_n  = phase;
    bitcnt_n = bitcnt;
    sample   = 1'b0;
    store    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (enable) state_n = SETUP;
      end
      SETUP: begin
        if (cnt == D_LAST) begin
          state_n  = SHIFT;
          cnt_n    = '0;
          phase_n  = 1'b0;
          bitcnt_n = '0;
        end
      end
      SHIFT: begin
        if (cnt == D_LAST) begin
          cnt_n = '0;
          if (!phase) begin
            phase_n = 1'b1;
            sample  = 1'b1;
          end else begin
            phase_n = 1'b0;
            if (bitcnt == 4'd15) state_n = STORE;
            else                 bitcnt_n = bitcnt + 4'd1;
          end
        end
      end
      STORE: begin
        store   = 1'b1;
        state_n = GAP;
        cnt_n   = '0;
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = enable ? SETUP : IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Current-channel stored value and valid flag, for the smoothing filter
  always_comb begin
    y_cur   = '0;
    vld_cur = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cur_ch == i[2:0]) begin
        y_cur   = mem[i];
        vld_cur = valid[i];
      end
    end
  end

  // IIR update; the arithmetic shift floors, so y+step always lies between y and x
  always_comb begin
    diff = $signed({1'b0, rx}) - $signed({1'b0, y_cur});
    step = diff >>> SMOOTH_SHIFT;
    sum  = $signed({1'b0, y_cur}) + step;
    if ((SMOOTH_SHIFT == 0) || !vld_cur) y_new = rx;
    else if (sum[ADC_BITS])              y_new = '0;
    else                                 y_new = sum[ADC_BITS-1:0];
  end

  // Readback port; channels at or beyond NUM_CH read as zero
  always_comb begin
    q = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (addr == i[2:0]) q = mem[i];
    end
  end

  // Receive shift, result store, channel advance and store strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      rx       <= '0;
      cur_ch   <= '0;
      valid    <= '0;
      smp_stb  <= 1'b0;
      smp_ch   <= '0;
      smp_data <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) mem[i] <= '0;
    end else begin
      smp_stb <= store;
      if (sample && in_window) rx <= {rx[ADC_BITS-2:0], din};
      if (store) begin
        cur_ch   <= nxt_ch;
        smp_ch   <= cur_ch;
        smp_data <= y_new;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (cur_ch == i[2:0]) begin
            mem[i]   <= y_new;
            valid[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule
